// File: rtl/cpu_mem_sys.sv
// Instruction/data memory subsystem for the 16-bit CPU. It has a registered fetch port,
// a wait-stated data port with a request/ready handshake, and a program-load port.
module cpu_mem_sys #(
    parameter int unsigned DW     = 16,
    parameter int unsigned IAW    = 7,
    parameter int unsigned DAW    = 7,
    parameter int unsigned IDEPTH = 128,
    parameter int unsigned DDEPTH = 128,
    parameter int unsigned WAIT   = 0,
    localparam int unsigned LAW   = (IAW > DAW) ? IAW : DAW
) (
    input  logic           CK,
    input  logic           RST,
    input  logic [IAW-1:0] IA,
    output logic [DW-1:0]  ID,
    input  logic           DREQ,
    input  logic           RW,
    input  logic [DAW-1:0] DA,
    input  logic [DW-1:0]  DDW,
    output logic [DW-1:0]  DDR,
    output logic           DRDY,
    output logic           BUSY,
    output logic           ERR,
    input  logic           LD_EN,
    input  logic           LD_SEL,
    input  logic [LAW-1:0] LD_ADDR,
    input  logic [DW-1:0]  LD_DATA
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CMPL = 2'd2;

    logic [DW-1:0] imem [IDEPTH];
    logic [DW-1:0] dmem [DDEPTH];

    logic [1:0]     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           rw_q, rw_d;
    logic [DAW-1:0] da_q, da_d;
    logic [DW-1:0]  ddw_q, ddw_d;
    logic [DW-1:0]  id_q, id_d;
    logic [DW-1:0]  ddr_q, ddr_d;
    logic           drdy_q, drdy_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;

    logic [IAW-1:0] ld_ia;
    logic [DAW-1:0] ld_da;
    logic           ia_ok, da_ok, ld_i_ok, ld_d_ok, cmpl_wr;

    assign ld_ia   = LD_ADDR[IAW-1:0];
    assign ld_da   = LD_ADDR[DAW-1:0];
    assign ia_ok   = 32'(IA) < IDEPTH;
    assign da_ok   = 32'(da_q) < DDEPTH;
    assign ld_i_ok = 32'(ld_ia) < IDEPTH;
    assign ld_d_ok = 32'(ld_da) < DDEPTH;
    assign cmpl_wr = (state_q == S_CMPL) && !rw_q && da_ok;

    always_comb begin
        id_d    = ia_ok ? imem[IA] : '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        da_d    = da_q;
        ddw_d   = ddw_q;
        ddr_d   = ddr_q;
        busy_d  = busy_q;
        drdy_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (DREQ) begin
                    rw_d    = RW;
                    da_d    = DA;
                    ddw_d   = DDW;
                    cnt_d   = 4'(WAIT);
                    busy_d  = 1'b1;
                    state_d = (WAIT == 0) ? S_CMPL : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_CMPL;
            end
            S_CMPL: begin
                if (rw_q) ddr_d = da_ok ? dmem[da_q] : '0;
                drdy_d  = 1'b1;
                err_d   = !da_ok;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            da_q    <= '0;
            ddw_q   <= '0;
            id_q    <= '0;
            ddr_q   <= '0;
            drdy_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            da_q    <= da_d;
            ddw_q   <= ddw_d;
            id_q    <= id_d;
            ddr_q   <= ddr_d;
            drdy_q  <= drdy_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Load write is issued last so it wins a same-address collision with a completing write.
    always_ff @(posedge CK) begin
        if (!RST) begin
            if (cmpl_wr) dmem[da_q] <= ddw_q;
            if (LD_EN && LD_SEL && ld_d_ok) dmem[ld_da] <= LD_DATA;
            if (LD_EN && !LD_SEL && ld_i_ok) imem[ld_ia] <= LD_DATA;
        end
    end

    assign ID   = id_q;
    assign DDR  = ddr_q;
    assign DRDY = drdy_q;
    assign BUSY = busy_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_cpu_mem_sys.sv
// Self-checking bench for cpu_mem_sys: four instances with different wait counts,
// directed scenarios plus random traffic against a transaction-deadline reference model.
module tb_cpu_mem_sys;

    localparam int NI   = 4;
    localparam int IDEP = 120;
    localparam int DDEP = 100;

    function automatic int wt(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst     [NI];
    logic [6:0]  ia      [NI];
    logic [15:0] id_o    [NI];
    logic        dreq    [NI];
    logic        rw      [NI];
    logic [6:0]  da      [NI];
    logic [15:0] ddw     [NI];
    logic [15:0] ddr_o   [NI];
    logic        drdy_o  [NI];
    logic        busy_o  [NI];
    logic        err_o   [NI];
    logic        ld_en   [NI];
    logic        ld_sel  [NI];
    logic [6:0]  ld_addr [NI];
    logic [15:0] ld_data [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        cpu_mem_sys #(
            .DW(16), .IAW(7), .DAW(7), .IDEPTH(IDEP), .DDEPTH(DDEP),
            .WAIT((k == 0) ? 0 : k + 1)
        ) u_dut (
            .CK(clk), .RST(rst[k]), .IA(ia[k]), .ID(id_o[k]),
            .DREQ(dreq[k]), .RW(rw[k]), .DA(da[k]), .DDW(ddw[k]),
            .DDR(ddr_o[k]), .DRDY(drdy_o[k]), .BUSY(busy_o[k]), .ERR(err_o[k]),
            .LD_EN(ld_en[k]), .LD_SEL(ld_sel[k]), .LD_ADDR(ld_addr[k]), .LD_DATA(ld_data[k])
        );
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic string tg(input string s, input int k);
        return $sformatf("%s%0d", s, k);
    endfunction

    // Reference model: a request completes exactly wt(k)+1 edges after acceptance.
    logic [15:0] m_i   [NI][128];
    bit          m_ik  [NI][128];
    logic [15:0] m_d   [NI][128];
    bit          m_dk  [NI][128];
    bit          live  [NI];
    bit          pend  [NI];
    int          done_at [NI];
    logic        p_rw  [NI];
    logic [6:0]  p_da  [NI];
    logic [15:0] p_dw  [NI];
    logic [15:0] e_id  [NI];
    bit          e_idk [NI];
    logic [15:0] e_ddr [NI];
    bit          e_ddrk[NI];
    logic        e_drdy[NI];
    logic        e_err [NI];
    int          cyc = 0;

    always @(posedge clk) begin
        cyc++;
        for (int k = 0; k < NI; k++) begin
            if (rst[k]) begin
                live[k] = 1; pend[k] = 0;
                e_id[k] = '0; e_idk[k] = 1; e_ddr[k] = '0; e_ddrk[k] = 1;
                e_drdy[k] = 0; e_err[k] = 0;
            end else begin
                bit cw;
                bit oor;
                cw = 0;
                e_drdy[k] = 0; e_err[k] = 0;
                if (int'(ia[k]) < IDEP) begin
                    e_id[k] = m_i[k][ia[k]]; e_idk[k] = m_ik[k][ia[k]];
                end else begin
                    e_id[k] = '0; e_idk[k] = 1;
                end
                if (pend[k] && cyc == done_at[k]) begin
                    oor = int'(p_da[k]) >= DDEP;
                    if (p_rw[k]) begin
                        e_ddr[k]  = oor ? 16'h0 : m_d[k][p_da[k]];
                        e_ddrk[k] = oor ? 1'b1 : m_dk[k][p_da[k]];
                    end else if (!oor) begin
                        cw = 1;
                    end
                    e_drdy[k] = 1; e_err[k] = oor; pend[k] = 0;
                end else if (!pend[k] && dreq[k]) begin
                    pend[k] = 1; done_at[k] = cyc + wt(k) + 1;
                    p_rw[k] = rw[k]; p_da[k] = da[k]; p_dw[k] = ddw[k];
                end
                if (cw) begin
                    m_d[k][p_da[k]] = p_dw[k]; m_dk[k][p_da[k]] = 1;
                end
                if (ld_en[k]) begin
                    if (ld_sel[k] && int'(ld_addr[k]) < DDEP) begin
                        m_d[k][ld_addr[k]] = ld_data[k]; m_dk[k][ld_addr[k]] = 1;
                    end else if (!ld_sel[k] && int'(ld_addr[k]) < IDEP) begin
                        m_i[k][ld_addr[k]] = ld_data[k]; m_ik[k][ld_addr[k]] = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (live[k]) begin
                chk(tg("busy", k), 32'(busy_o[k]), 32'(pend[k]));
                chk(tg("drdy", k), 32'(drdy_o[k]), 32'(e_drdy[k]));
                chk(tg("err", k), 32'(err_o[k]), 32'(e_err[k]));
                if (e_idk[k]) chk(tg("id", k), 32'(id_o[k]), 32'(e_id[k]));
                if (e_ddrk[k]) chk(tg("ddr", k), 32'(ddr_o[k]), 32'(e_ddr[k]));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Issue one access with the port idle; returns read data and ERR seen with DRDY.
    task automatic access(input int k, input logic r, input logic [6:0] a, input logic [15:0] d,
                          input bit noise, output logic [15:0] q, output logic e);
        int n;
        dreq[k] = 1; rw[k] = r; da[k] = a; ddw[k] = d;
        step();
        dreq[k] = 0;
        n = 0;
        while (!drdy_o[k] && n < 40) begin
            if (noise) begin
                dreq[k] = 1'($urandom); rw[k] = 1'($urandom);
                da[k] = 7'($urandom); ddw[k] = 16'($urandom);
            end
            step();
            n++;
        end
        dreq[k] = 0;
        chk(tg("lat", k), 32'(n), 32'(wt(k) + 1));
        q = ddr_o[k];
        e = err_o[k];
    endtask

    logic [15:0] itab [4];
    logic [15:0] q;
    logic        e;

    initial begin
        itab[0] = 16'hC100; itab[1] = 16'hC101; itab[2] = 16'h0112; itab[3] = 16'hA017;
        for (int k = 0; k < NI; k++) begin
            rst[k] = 1; ia[k] = '0; dreq[k] = 0; rw[k] = 0; da[k] = '0; ddw[k] = '0;
            ld_en[k] = 0; ld_sel[k] = 0; ld_addr[k] = '0; ld_data[k] = '0;
        end
        step();
        chk("rst_id", 32'(id_o[0]), 32'h0);
        chk("rst_busy", 32'(busy_o[1]), 32'h0);
        step();
        for (int k = 0; k < NI; k++) rst[k] = 0;

        // Preload every location of both memories, including the dropped out-of-range ones.
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 128; a++) begin
                for (int k = 0; k < NI; k++) begin
                    ld_en[k] = 1; ld_sel[k] = 1'(s); ld_addr[k] = 7'(a); ld_data[k] = 16'($urandom);
                end
                step();
            end
        end
        for (int i = 0; i < 4; i++) begin
            ld_sel[0] = 0; ld_addr[0] = 7'(i); ld_data[0] = itab[i];
            ld_sel[3] = 1; ld_addr[3] = 7'd9; ld_data[3] = 16'h0042;
            step();
        end
        for (int k = 0; k < NI; k++) ld_en[k] = 0;

        for (int i = 0; i < 4; i++) begin
            ia[0] = 7'(i);
            step();
            chk($sformatf("fetch%0d", i), 32'(id_o[0]), 32'(itab[i]));
        end
        ia[0] = 7'd119;
        step();
        ia[0] = 7'd120;
        step();
        chk("fetch_oor", 32'(id_o[0]), 32'h0);

        access(0, 1'b0, 7'd5, 16'h1234, 0, q, e);
        chk("w0_err", 32'(e), 32'h0);
        access(0, 1'b1, 7'd5, 16'h0000, 0, q, e);
        chk("w0_rd", 32'(q), 32'h1234);
        chk("w0_rerr", 32'(e), 32'h0);

        access(2, 1'b0, 7'd20, 16'hBEEF, 0, q, e);
        access(2, 1'b1, 7'd20, 16'h0000, 1, q, e);
        chk("w3_rd", 32'(q), 32'hBEEF);

        access(0, 1'b0, 7'd120, 16'h7777, 0, q, e);
        chk("oor_werr", 32'(e), 32'h1);
        access(0, 1'b1, 7'd120, 16'h0000, 0, q, e);
        chk("oor_rerr", 32'(e), 32'h1);
        chk("oor_rd", 32'(q), 32'h0);

        // Load lands on the same edge as the completing write to the same address.
        dreq[1] = 1; rw[1] = 0; da[1] = 7'd7; ddw[1] = 16'hAAAA;
        step();
        dreq[1] = 0;
        step();
        step();
        ld_en[1] = 1; ld_sel[1] = 1; ld_addr[1] = 7'd7; ld_data[1] = 16'h5555;
        step();
        ld_en[1] = 0;
        chk("coll_drdy", 32'(drdy_o[1]), 32'h1);
        access(1, 1'b1, 7'd7, 16'h0000, 0, q, e);
        chk("coll_rd", 32'(q), 32'h5555);

        dreq[3] = 1; rw[3] = 0; da[3] = 7'd9; ddw[3] = 16'hFFFF;
        step();
        dreq[3] = 0;
        step();
        rst[3] = 1;
        step();
        rst[3] = 0;
        chk("abort_busy", 32'(busy_o[3]), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_drdy", 32'(drdy_o[3]), 32'h0);
        end
        access(3, 1'b1, 7'd9, 16'h0000, 0, q, e);
        chk("abort_rd", 32'(q), 32'h0042);

        repeat (400) begin
            for (int k = 0; k < NI; k++) begin
                rst[k]     = ($urandom_range(0, 63) == 0);
                ia[k]      = 7'($urandom);
                dreq[k]    = 1'($urandom);
                rw[k]      = 1'($urandom);
                da[k]      = 7'($urandom);
                ddw[k]     = 16'($urandom);
                ld_en[k]   = ($urandom_range(0, 3) == 0);
                ld_sel[k]  = 1'($urandom);
                ld_addr[k] = 7'($urandom);
                ld_data[k] = 16'($urandom);
            end
            step();
        end
        for (int k = 0; k < NI; k++) begin
            rst[k] = 0; dreq[k] = 0; ld_en[k] = 0;
        end
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
